// File: rtl/neurona_mac.sv
// rtl/neurona_mac.sv - serial multiply-accumulate producing one neuron's saturated pre-activation sum
module neurona_mac #(
    parameter int Signo     = 1,
    parameter int Magnitud  = 7,
    parameter int Precision = 24,
    parameter int Width     = Signo + Magnitud + Precision,
    parameter int NEntradas = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Inicio,
    input  logic [Width-1:0] Sesgo,
    input  logic             EntradaValida,
    input  logic [Width-1:0] Entrada,
    input  logic [Width-1:0] Peso,
    output logic             Ocupado,
    output logic             Listo,
    output logic [Width-1:0] Salida,
    output logic             Error
);

    // Eight guard bits let up to 255 saturated products plus the bias add without wrapping.
    localparam int AccW = Width + 8;
    // Product bits above the kept window, including the kept sign bit.
    localparam int HiW  = Width - Precision + 1;

    localparam logic [Width-1:0] MaxVal = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};
    localparam logic [7:0]       Ultima = 8'(NEntradas - 1);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        ACUMULA = 2'd1,
        FINAL   = 2'd2
    } estado_t;

    estado_t              state_q, state_d;
    logic [AccW-1:0]      acc_q, acc_d;
    logic [7:0]           cuenta_q, cuenta_d;
    logic                 err_int_q, err_int_d;
    logic [Width-1:0]     salida_q, salida_d;
    logic                 error_q, error_d;
    logic                 listo_q, listo_d;
    logic                 ocupado_q;

    logic signed [2*Width-1:0] prod;
    logic [HiW-1:0]            prod_hi;
    logic                      prod_ovf;
    logic [Width-1:0]          prod_sat;
    logic [8:0]                acc_hi;
    logic                      acc_ovf;
    logic [Width-1:0]          acc_sat;
    logic                      unused_prod_lo;

    assign prod           = $signed(Entrada) * $signed(Peso);
    assign unused_prod_lo = ^prod[Precision-1:0];

    // Rescale the product to the data format, clamping when it leaves the Width range.
    always_comb begin
        prod_hi  = prod[2*Width-1:Precision+Width-1];
        prod_ovf = !((&prod_hi) || !(|prod_hi));
        if (prod_ovf) begin
            prod_sat = prod[2*Width-1] ? MinVal : MaxVal;
        end else begin
            prod_sat = prod[Precision+Width-1:Precision];
        end
    end

    // Clamp the wide accumulator back into the output word.
    always_comb begin
        acc_hi  = acc_q[AccW-1:Width-1];
        acc_ovf = !((&acc_hi) || !(|acc_hi));
        if (acc_ovf) begin
            acc_sat = acc_q[AccW-1] ? MinVal : MaxVal;
        end else begin
            acc_sat = acc_q[Width-1:0];
        end
    end

    // Next-state and datapath updates for the three-phase sequence.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cuenta_d  = cuenta_q;
        err_int_d = err_int_q;
        salida_d  = salida_q;
        error_d   = error_q;
        listo_d   = 1'b0;
        case (state_q)
            REPOSO: begin
                if (Inicio) begin
                    state_d   = ACUMULA;
                    acc_d     = {{8{Sesgo[Width-1]}}, Sesgo};
                    cuenta_d  = 8'd0;
                    err_int_d = 1'b0;
                end
            end
            ACUMULA: begin
                if (EntradaValida) begin
                    acc_d     = acc_q + {{8{prod_sat[Width-1]}}, prod_sat};
                    cuenta_d  = cuenta_q + 8'd1;
                    err_int_d = err_int_q | prod_ovf;
                    if (cuenta_q == Ultima) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                state_d  = REPOSO;
                salida_d = acc_sat;
                error_d  = err_int_q | acc_ovf;
                listo_d  = 1'b1;
            end
            default: begin
                state_d = REPOSO;
            end
        endcase
    end

    // State and result registers; reset discards any sum in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= REPOSO;
            acc_q     <= '0;
            cuenta_q  <= 8'd0;
            err_int_q <= 1'b0;
            salida_q  <= '0;
            error_q   <= 1'b0;
            listo_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cuenta_q  <= cuenta_d;
            err_int_q <= err_int_d;
            salida_q  <= salida_d;
            error_q   <= error_d;
            listo_q   <= listo_d;
            ocupado_q <= (state_d != REPOSO);
        end
    end

    assign Ocupado = ocupado_q;
    assign Listo   = listo_q;
    assign Salida  = salida_q;
    assign Error   = error_q;

endmodule

// File: tb/tb_neurona_mac.sv
// tb/tb_neurona_mac.sv - scoreboard bench for neurona_mac
module tb_neurona_mac;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Inicio = 1'b0;
    logic        EntradaValida = 1'b0;
    logic [31:0] Sesgo = 32'd0;
    logic [31:0] Entrada = 32'd0;
    logic [31:0] Peso = 32'd0;
    logic        Ocupado, Listo, Error;
    logic [31:0] Salida;

    int n_vec = 0;
    int n_bad = 0;

    logic [32:0] sb_q[$];
    logic [32:0] hold_v = 33'd0;
    logic        prev_listo = 1'b0;

    localparam longint MAXV = 64'sh7FFFFFFF;
    localparam longint MINV = -64'sh80000000;

    always #5 CLK = ~CLK;

    neurona_mac #(.NEntradas(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .Inicio(Inicio),
        .Sesgo(Sesgo),
        .EntradaValida(EntradaValida),
        .Entrada(Entrada),
        .Peso(Peso),
        .Ocupado(Ocupado),
        .Listo(Listo),
        .Salida(Salida),
        .Error(Error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] ses,
                                          input logic [31:0] e[4],
                                          input logic [31:0] w[4]);
        longint acc;
        longint p;
        bit     err;
        err = 1'b0;
        acc = longint'($signed(ses));
        for (int i = 0; i < 4; i++) begin
            p = (longint'($signed(e[i])) * longint'($signed(w[i]))) >>> 24;
            if (p > MAXV) begin
                p = MAXV;
                err = 1'b1;
            end else if (p < MINV) begin
                p = MINV;
                err = 1'b1;
            end
            acc = acc + p;
        end
        if (acc > MAXV) begin
            acc = MAXV;
            err = 1'b1;
        end else if (acc < MINV) begin
            acc = MINV;
            err = 1'b1;
        end
        return {err, acc[31:0]};
    endfunction

    always @(negedge CLK) begin
        if (RST) begin
            hold_v <= 33'd0;
        end else if (Listo) begin
            chk("listo_pulse", {63'd0, prev_listo}, 64'd0);
            if (sb_q.size() == 0) begin
                chk("sb_underflow", {63'd0, Listo}, 64'd0);
            end else begin
                chk("result", {31'd0, Error, Salida}, {31'd0, sb_q[0]});
                hold_v <= sb_q[0];
                void'(sb_q.pop_front());
            end
        end else begin
            chk("hold", {31'd0, Error, Salida}, {31'd0, hold_v});
        end
        prev_listo <= Listo;
    end

    task automatic run_op(input string tag, input logic [31:0] ses,
                          input logic [31:0] e[4], input logic [31:0] w[4],
                          input int stall, input bit noise, input logic [32:0] exp);
        int lat;
        bit seen;
        sb_q.push_back(exp);
        Inicio = 1'b1;
        Sesgo  = ses;
        if (noise) begin
            EntradaValida = 1'b1;
            Entrada = 32'h7FFFFFFF;
            Peso    = 32'h7FFFFFFF;
        end
        @(posedge CLK); #1;
        lat = 1;
        Inicio = 1'b0;
        EntradaValida = 1'b0;
        Sesgo = ~ses;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int s = 0; s < stall; s++) begin
                    Entrada = 32'h7FFFFFFF;
                    Peso    = 32'h7FFFFFFF;
                    if (noise) Inicio = 1'b1;
                    @(posedge CLK); #1;
                    lat++;
                    Inicio = 1'b0;
                    chk({tag, "_busy_stall"}, {63'd0, Ocupado}, 64'd1);
                end
            end
            Entrada = e[i];
            Peso    = w[i];
            EntradaValida = 1'b1;
            @(posedge CLK); #1;
            lat++;
            EntradaValida = 1'b0;
            chk({tag, "_busy"}, {63'd0, Ocupado}, 64'd1);
        end
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            if (Listo) seen = 1'b1;
            else begin
                @(posedge CLK); #1;
                lat++;
            end
        end
        chk({tag, "_listo_seen"}, {63'd0, seen}, 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(6 + 3 * stall));
        chk({tag, "_idle_at_listo"}, {63'd0, Ocupado}, 64'd0);
    endtask

    initial begin
        logic [31:0] ea[4];
        logic [31:0] wa[4];
        logic [31:0] zr[4];
        logic [31:0] rs;
        zr = '{32'd0, 32'd0, 32'd0, 32'd0};

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_salida", {32'd0, Salida}, 64'd0);
        chk("rst_error", {63'd0, Error}, 64'd0);
        chk("rst_listo", {63'd0, Listo}, 64'd0);
        chk("rst_ocupado", {63'd0, Ocupado}, 64'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        ea = '{32'h01000000, 32'h02000000, 32'hFF000000, 32'h00800000};
        wa = '{32'h00800000, 32'h00400000, 32'h01000000, 32'h02000000};
        run_op("nominal", 32'h00800000, ea, wa, 0, 1'b0, {1'b0, 32'h01800000});

        ea = '{32'h0A000000, 32'h0A000000, 32'h0A000000, 32'h0A000000};
        run_op("pos_sat", 32'h64000000, ea, ea, 0, 1'b0, {1'b1, 32'h7FFFFFFF});

        run_op("zeros", 32'h00000000, zr, zr, 0, 1'b0, {1'b0, 32'h00000000});

        ea = '{32'h9C000000, 32'd0, 32'd0, 32'd0};
        wa = '{32'h64000000, 32'd0, 32'd0, 32'd0};
        run_op("prod_ovf", 32'h00000000, ea, wa, 0, 1'b0, {1'b1, 32'h80000000});

        ea = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
        wa = '{32'h00800000, 32'd0, 32'd0, 32'd0};
        run_op("floor", 32'h00000000, ea, wa, 0, 1'b0, {1'b0, 32'hFFFFFFFF});

        ea = '{32'h01000000, 32'h02000000, 32'hFF000000, 32'h00800000};
        wa = '{32'h00800000, 32'h00400000, 32'h01000000, 32'h02000000};
        run_op("stall", 32'h00800000, ea, wa, 3, 1'b1, {1'b0, 32'h01800000});

        Inicio = 1'b1;
        Sesgo  = 32'h00800000;
        @(posedge CLK); #1;
        Inicio = 1'b0;
        for (int i = 0; i < 2; i++) begin
            Entrada = ea[i];
            Peso    = wa[i];
            EntradaValida = 1'b1;
            @(posedge CLK); #1;
        end
        EntradaValida = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("midrst_salida", {32'd0, Salida}, 64'd0);
        chk("midrst_error", {63'd0, Error}, 64'd0);
        chk("midrst_listo", {63'd0, Listo}, 64'd0);
        chk("midrst_ocupado", {63'd0, Ocupado}, 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        run_op("after_rst", 32'h00800000, ea, wa, 0, 1'b0, {1'b0, 32'h01800000});

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                ea[i] = $urandom();
                wa[i] = $urandom();
                if (r < 4) begin
                    ea[i] = $signed(ea[i]) >>> 5;
                    wa[i] = $signed(wa[i]) >>> 5;
                end
            end
            rs = $urandom();
            if (r < 4) rs = $signed(rs) >>> 4;
            run_op("random", rs, ea, wa, r % 2, 1'b0, model(rs, ea, wa));
        end

        repeat (2) @(posedge CLK);
        #1;
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
